// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised 2-read/1-write register file with registered debug port and commit counter
module reg_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic              dbg_valid,
    output logic [15:0]       wr_count
);
    localparam int N = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [N];
    logic [N-1:0]     written;
    logic             commit;
    logic             dbg_zero;

    assign commit   = we3 && !(ZERO_REG != 0 && wa3 == '0);
    assign dbg_zero = ZERO_REG != 0 && dbg_addr == '0;

    // storage, written flags and commit counter; writes to a hardwired r0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            written  <= '0;
            wr_count <= '0;
        end else if (commit) begin
            regs[wa3]    <= wd3;
            written[wa3] <= 1'b1;
            wr_count     <= wr_count + 16'd1;
        end
    end

    // debug snapshot samples pre-write state, so a same-edge write shows up one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data  <= '0;
            dbg_valid <= 1'b0;
        end else begin
            dbg_data  <= dbg_zero ? '0 : regs[dbg_addr];
            dbg_valid <= dbg_zero ? 1'b0 : written[dbg_addr];
        end
    end

    // read ports: hardwired zero beats write forwarding, which beats stored value
    always_comb begin
        rd1 = (ZERO_REG != 0 && ra1 == '0) ? '0 :
              (BYPASS != 0 && we3 && wa3 == ra1) ? wd3 : regs[ra1];
        rd2 = (ZERO_REG != 0 && ra2 == '0) ? '0 :
              (BYPASS != 0 && we3 && wa3 == ra2) ? wd3 : regs[ra2];
    end

    we3_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(we3))
        else $error("we3 is X while out of reset");
endmodule
